// File: rtl/ahp_mem_slave_pkg.sv
// Shared types and constants for the AHP memory slave: transfer encodings,
// FSM states, HSIZE/HRESP constants and the byte-lane mask helper.
package ahp_mem_slave_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slave_state_e;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int unsigned WAIT_CNT_W = 3;

  // Byte lanes touched by a transfer starting at lane lo; sized for up to 64-bit buses.
  function automatic logic [7:0] f_lane_mask(input logic [2:0] lo, input logic [2:0] size);
    logic [7:0]  m;
    int unsigned n;
    m = '0;
    n = 32'd1 << size;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((i >= 32'(lo)) && (i < (32'(lo) + n))) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ahp_mem_slave_bytelane.sv
// Byte-enabled word memory: synchronous write port, asynchronous read port.
module ahp_mem_slave_bytelane
  import ahp_mem_slave_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_waddr,
  input  logic [DATA_W/8-1:0]   i_be,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [IDX_W-1:0]      i_raddr,
  output logic [DATA_W-1:0]     o_rdata
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ahp_mem_slave.sv
// Parametrised AHB-Lite memory slave with wait states, ERROR response and write-to-read forwarding.
// Optional read-only upper region enabled by AHP_MEM_SLAVE_RO_REGION_EN.
module ahp_mem_slave
  import ahp_mem_slave_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned RO_BASE     = MEM_BYTES / 2
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HBURST,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HADDR,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned LOG2B  = $clog2(NB);
  localparam int unsigned MEM_AW = $clog2(MEM_BYTES);
  localparam int unsigned DEPTH  = MEM_BYTES / NB;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  slave_state_e            r_state, w_nxt_state;
  logic [WAIT_CNT_W-1:0]   r_cnt, w_nxt_cnt;
  logic                    r_dp_ok, w_nxt_dp_ok;
  logic                    r_write;
  logic [2:0]              r_size;
  logic [MEM_AW-1:0]       r_addr;
  logic [DATA_W-1:0]       r_hrdata, w_nxt_rdata;
  logic                    r_hreadyout, w_nxt_ready;
  logic                    r_hresp, w_nxt_resp;

  logic                    w_can_accept, w_accept, w_err, w_ro_err;
  logic                    w_wr_en, w_fwd;
  logic [IDX_W-1:0]        w_wr_idx, w_rd_idx;
  logic [NB-1:0]           w_wr_be, w_rd_be;
  logic [DATA_W-1:0]       w_mem_rdata, w_rd_merged;
  logic                    w_unused;

  assign w_unused = ^{HBURST, 32'(RO_BASE)};

  // Address phase sampling; ERR2 and the completing cycle both drive HREADYOUT high.
  assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_ERR2);
  assign w_accept     = w_can_accept && HSEL && HREADY &&
                        ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

`ifdef AHP_MEM_SLAVE_RO_REGION_EN
  assign w_ro_err = HWRITE && (32'(HADDR[MEM_AW-1:0]) >= 32'(RO_BASE));
`else
  assign w_ro_err = 1'b0;
`endif

  assign w_err = (HSIZE > 3'(LOG2B)) ||
                 ((HADDR & ((32'd1 << HSIZE) - 32'd1)) != 32'd0) ||
                 ((HADDR >> MEM_AW) != 32'd0) ||
                 w_ro_err;

  // A data phase in IDLE with r_dp_ok set is always the completing cycle.
  assign w_wr_en  = (r_state == ST_IDLE) && r_dp_ok && r_write;
  assign w_wr_idx = IDX_W'(r_addr >> LOG2B);
  assign w_wr_be  = NB'(f_lane_mask(3'(r_addr[LOG2B-1:0]), r_size));

  assign w_rd_idx = (r_state == ST_WAIT) ? IDX_W'(r_addr >> LOG2B)
                                         : IDX_W'(HADDR[MEM_AW-1:0] >> LOG2B);
  assign w_rd_be  = (r_state == ST_WAIT) ? NB'(f_lane_mask(3'(r_addr[LOG2B-1:0]), r_size))
                                         : NB'(f_lane_mask(3'(HADDR[LOG2B-1:0]), HSIZE));

  assign w_fwd = w_wr_en && (w_wr_idx == w_rd_idx);

  ahp_mem_slave_bytelane #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .i_clk   (HCLK),
    .i_we    (w_wr_en),
    .i_waddr (w_wr_idx),
    .i_be    (w_wr_be),
    .i_wdata (HWDATA),
    .i_raddr (w_rd_idx),
    .o_rdata (w_mem_rdata)
  );

  // Read word with the in-flight write merged in; lanes outside the transfer forced to 0.
  always_comb begin
    w_rd_merged = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (w_rd_be[i]) begin
        if (w_fwd && w_wr_be[i]) w_rd_merged[8*i +: 8] = HWDATA[8*i +: 8];
        else                     w_rd_merged[8*i +: 8] = w_mem_rdata[8*i +: 8];
      end
    end
  end

  // Next-state and next-output logic; outputs describe the following cycle.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_dp_ok = r_dp_ok;
    w_nxt_ready = 1'b1;
    w_nxt_resp  = HRESP_OKAY;
    w_nxt_rdata = '0;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        w_nxt_state = ST_IDLE;
        w_nxt_dp_ok = 1'b0;
        if (w_accept) begin
          if (w_err) begin
            w_nxt_state = ST_ERR1;
            w_nxt_ready = 1'b0;
            w_nxt_resp  = HRESP_ERROR;
          end else begin
            w_nxt_dp_ok = 1'b1;
            if (WAIT_STATES > 0) begin
              w_nxt_state = ST_WAIT;
              w_nxt_cnt   = WAIT_CNT_W'(WAIT_STATES);
              w_nxt_ready = 1'b0;
            end else if (!HWRITE) begin
              w_nxt_rdata = w_rd_merged;
            end
          end
        end
      end
      ST_WAIT: begin
        w_nxt_cnt = r_cnt - WAIT_CNT_W'(1);
        if (r_cnt <= WAIT_CNT_W'(1)) begin
          w_nxt_state = ST_IDLE;
          if (!r_write) w_nxt_rdata = w_rd_merged;
        end else begin
          w_nxt_ready = 1'b0;
        end
      end
      ST_ERR1: begin
        w_nxt_state = ST_ERR2;
        w_nxt_resp  = HRESP_ERROR;
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_dp_ok     <= 1'b0;
      r_write     <= 1'b0;
      r_size      <= '0;
      r_addr      <= '0;
      r_hrdata    <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_dp_ok     <= w_nxt_dp_ok;
      r_hrdata    <= w_nxt_rdata;
      r_hreadyout <= w_nxt_ready;
      r_hresp     <= w_nxt_resp;
      if (w_accept) begin
        r_addr  <= HADDR[MEM_AW-1:0];
        r_size  <= HSIZE;
        r_write <= HWRITE;
      end
    end
  end

  assign HRDATA    = r_hrdata;
  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;

endmodule

// File: tb/tb_ahp_mem_slave.sv
// Scoreboard bench: two slaves (0 and 2 wait states) on one bus, byte-array reference model.
module tb_ahp_mem_slave;
  import ahp_mem_slave_pkg::*;

  localparam int unsigned NB  = 4;
  localparam int unsigned LB  = 2;
  localparam int unsigned MEM = 1024;
  localparam int unsigned RO  = MEM / 2;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        hsel0, hsel2, act;
  logic [1:0]  htrans;
  logic [2:0]  hburst, hsize;
  logic        hwrite;
  logic [31:0] haddr, hwdata;
  logic [31:0] rdata0, rdata2;
  logic        rdy0, rdy2, resp0, resp2;
  logic        hready;

  assign hready = act ? rdy2 : rdy0;

  always #5 HCLK = ~HCLK;

  ahp_mem_slave #(.DATA_W(32), .MEM_BYTES(MEM), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HREADY(hready), .HTRANS(htrans),
    .HBURST(hburst), .HWRITE(hwrite), .HSIZE(hsize), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0));

  ahp_mem_slave #(.DATA_W(32), .MEM_BYTES(MEM), .WAIT_STATES(2)) u_dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel2), .HREADY(hready), .HTRANS(htrans),
    .HBURST(hburst), .HWRITE(hwrite), .HSIZE(hsize), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rdata2), .HREADYOUT(rdy2), .HRESP(resp2));

  typedef struct { logic write; logic [2:0] size; logic [31:0] addr; logic [31:0] wdata; } txn_t;
  typedef struct { logic err; int waits; logic [31:0] rdata; logic [31:0] mask; } exp_t;

  txn_t        txq[$];
  exp_t        sbq[$];
  logic [7:0]  mdl [2][MEM];
  bit          kn  [2][MEM];
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;
  bit          gaps_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic model_err(input txn_t t);
    logic e;
    e = (t.size > 3'(LB)) || ((t.addr % (32'd1 << t.size)) != 0) || (t.addr >= MEM);
`ifdef AHP_MEM_SLAVE_RO_REGION_EN
    if (t.write && (t.addr < MEM) && (t.addr >= RO)) e = 1'b1;
`endif
    return e;
  endfunction

  // Sequential memory model: applies transfers in bus order and queues the expected response.
  task automatic model_issue(input txn_t t);
    exp_t x;
    int s, base, lo, n;
    s = act ? 1 : 0;
    x.err = model_err(t);
    x.waits = x.err ? 1 : (act ? 2 : 0);
    x.rdata = '0;
    x.mask = '1;
    if (!x.err) begin
      base = int'(t.addr) - int'(t.addr % NB);
      lo = int'(t.addr % NB);
      n = 1 << t.size;
      for (int i = lo; i < lo + n; i++) begin
        if (t.write) begin
          mdl[s][base+i] = t.wdata[8*i +: 8];
          kn[s][base+i] = 1'b1;
        end else begin
          x.rdata[8*i +: 8] = mdl[s][base+i];
          if (!kn[s][base+i]) x.mask[8*i +: 8] = 8'h00;
        end
      end
    end
    sbq.push_back(x);
  endtask

  task automatic push(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.write = w; t.size = sz; t.addr = a; t.wdata = d;
    txq.push_back(t);
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    int k;
    t.write = 1'($urandom_range(0, 1));
    t.wdata = $urandom();
    k = int'($urandom_range(0, 15));
    if (k < 12) begin
      t.size = 3'($urandom_range(0, 2));
      t.addr = (k < 7) ? 32'($urandom_range(0, 63)) : 32'($urandom_range(0, MEM-1));
      t.addr = t.addr & ~((32'd1 << t.size) - 32'd1);
    end else if (k == 12) begin
      t.size = 3'($urandom_range(1, 2));
      t.addr = (32'($urandom_range(0, 63)) & ~32'd3) | 32'd1;
    end else if (k == 13) begin
      t.size = 3'($urandom_range(3, 7));
      t.addr = 32'($urandom_range(0, 63)) & ~32'd3;
    end else if (k == 14) begin
      t.size = 3'd2;
      t.addr = MEM + (32'($urandom_range(0, 255)) << 2);
    end else begin
      t.size = 3'd2;
      t.addr = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
    end
    return t;
  endfunction

  task automatic set_sel(input logic s);
    hsel0 = s && !act;
    hsel2 = s && act;
  endtask

  task automatic drive_idle();
    set_sel(1'b1);
    htrans = HTRANS_IDLE;
  endtask

  task automatic drive_gap();
    case ($urandom_range(0, 2))
      0: begin set_sel(1'b1); htrans = HTRANS_IDLE; end
      1: begin set_sel(1'b1); htrans = HTRANS_BUSY; hwrite = 1'b1; haddr = 32'h10; end
      default: begin
        set_sel(1'b0); htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h10;
      end
    endcase
  endtask

  task automatic drive_txn(input txn_t t);
    set_sel(1'b1);
    htrans = ($urandom_range(0, 1) != 0) ? HTRANS_SEQ : HTRANS_NONSEQ;
    hburst = 3'($urandom_range(0, 7));
    hwrite = t.write;
    hsize  = t.size;
    haddr  = t.addr;
  endtask

  // Pipelined master: address phase held while HREADY is low, HWDATA during the data phase.
  task automatic run_queue();
    txn_t cur, dp;
    bit cur_act, dp_act, need_new, rdy;
    int guard;
    cur_act = 0; dp_act = 0; need_new = 1; guard = 0;
    cur = '{1'b0, 3'd0, 32'd0, 32'd0};
    while (1) begin
      if (need_new) begin
        cur_act = 0;
        if (txq.size() == 0) begin
          drive_idle();
          if (!dp_act) break;
        end else if (gaps_en && ($urandom_range(0, 4) == 0)) begin
          drive_gap();
        end else begin
          cur = txq.pop_front();
          drive_txn(cur);
          model_issue(cur);
          cur_act = 1;
        end
      end
      @(negedge HCLK); rdy = hready;
      @(posedge HCLK); #1;
      if (rdy) begin
        dp_act = cur_act;
        dp = cur;
        hwdata = (dp_act && dp.write) ? dp.wdata : $urandom();
        need_new = 1;
      end else begin
        need_new = 0;
      end
      guard++;
      if (guard > 20000) begin
        checks++; failures++;
        $display("FAIL driver_timeout got=%0d exp=<20000 cycles", guard);
        break;
      end
    end
  endtask

  // Monitor: counts wait cycles, pops the scoreboard on each completing data phase.
  initial begin
    logic r, e;
    logic [31:0] d;
    exp_t x;
    bit dp_pend;
    int low_cnt;
    dp_pend = 0; low_cnt = 0;
    forever begin
      @(negedge HCLK);
      r = act ? rdy2 : rdy0;
      d = act ? rdata2 : rdata0;
      e = act ? resp2 : resp0;
      if (!mon_en) begin
        dp_pend = 0; low_cnt = 0;
      end else begin
        if (dp_pend) begin
          if (sbq.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            dp_pend = 0;
          end else if (!r) begin
            x = sbq[0];
            chk("hresp_wait", 32'(e), 32'(x.err));
            low_cnt++;
            if (low_cnt > 16) begin
              chk("ready_timeout", 32'(low_cnt), 32'(x.waits));
              void'(sbq.pop_front());
              dp_pend = 0; low_cnt = 0;
            end
          end else begin
            x = sbq.pop_front();
            chk("hresp", 32'(e), 32'(x.err));
            chk("waits", 32'(low_cnt), 32'(x.waits));
            chk("hrdata", d & x.mask, x.rdata & x.mask);
            low_cnt = 0;
          end
        end
        if (r) dp_pend = (act ? hsel2 : hsel0) && htrans[1];
      end
    end
  end

  initial begin
    logic [31:0] old40;
    HRESETn = 1'b0; act = 1'b0;
    hsel0 = 1'b0; hsel2 = 1'b0; htrans = HTRANS_IDLE; hburst = '0;
    hwrite = 1'b0; hsize = 3'd2; haddr = '0; hwdata = '0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_ready0", 32'(rdy0), 32'd1);
    chk("rst_resp0",  32'(resp0), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_ready2", 32'(rdy2), 32'd1);
    chk("rst_resp2",  32'(resp2), 32'd0);
    chk("rst_rdata2", rdata2, 32'd0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    mon_en = 1'b1;

    for (int s = 0; s < 2; s++) begin
      act = 1'(s);
      for (int a = 0; a < MEM; a += 4) push(1'b1, 3'd2, 32'(a), $urandom());
      run_queue();
    end

    // Directed, back-to-back on both slaves.
    for (int s = 0; s < 2; s++) begin
      act = 1'(s);
      gaps_en = 1'b0;
      push(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
      push(1'b0, 3'd2, 32'h10, 32'h0);
      push(1'b1, 3'd0, 32'h13, 32'hAA5A5A5A);
      push(1'b0, 3'd2, 32'h10, 32'h0);
      push(1'b1, 3'd2, 32'h20, 32'h1234_5678);
      push(1'b0, 3'd2, 32'h20, 32'h0);
      push(1'b1, 3'd1, 32'h22, 32'hCAFE_0000);
      push(1'b0, 3'd0, 32'h23, 32'h0);
      push(1'b1, 3'd1, 32'h11, 32'hFFFF_FFFF);
      push(1'b0, 3'd1, 32'h11, 32'h0);
      push(1'b1, 3'd2, 32'h400, 32'hFFFF_FFFF);
      push(1'b0, 3'd2, 32'h10, 32'h0);
      push(1'b1, 3'd2, RO, 32'h0BAD_F00D);
      push(1'b0, 3'd2, RO, 32'h0);
      push(1'b0, 3'd2, MEM - 4, 32'h0);
      run_queue();

      gaps_en = 1'b1;
      for (int i = 0; i < 300; i++) txq.push_back(rand_txn());
      run_queue();
    end

    // Reset during a wait-state write: the write must be dropped.
    mon_en = 1'b0;
    act = 1'b1;
    old40 = {mdl[1][67], mdl[1][66], mdl[1][65], mdl[1][64]};
    set_sel(1'b1); htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h40;
    @(posedge HCLK); #1;
    htrans = HTRANS_IDLE; hwdata = ~old40;
    @(negedge HCLK);
    chk("mid_wait_ready", 32'(rdy2), 32'd0);
    HRESETn = 1'b0;
    #1;
    chk("async_rst_ready", 32'(rdy2), 32'd1);
    chk("async_rst_resp",  32'(resp2), 32'd0);
    chk("async_rst_rdata", rdata2, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    mon_en = 1'b1;
    gaps_en = 1'b0;
    push(1'b0, 3'd2, 32'h40, 32'h0);
    run_queue();

    repeat (3) @(posedge HCLK);
    if (sbq.size() != 0) chk("scoreboard_leftover", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
